// File: rtl/icache_direct_if.sv
// icache_direct_if
// Bundles the fetcher-side request/response signals and the memory-controller
// fetcher-port signals of the direct-mapped instruction cache.
//   slave  : cache view (takes requests, issues memory reads)
//   master : environment view (fetcher + memory controller)
// Signals:
//   fetch_valid/fetch_addr/fetch_ready : fetcher request handshake
//   out_valid/out_instr/out_addr       : one-cycle response
//   mem_req/mem_addr                   : word read toward the controller
//   mem_ready/mem_instr                : controller read completion
`timescale 1ns/1ps
interface icache_direct_if;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_instr;

    modport slave (
        input  fetch_valid, fetch_addr, mem_ready, mem_instr,
        output fetch_ready, out_valid, out_instr, out_addr, mem_req, mem_addr
    );

    modport master (
        output fetch_valid, fetch_addr, mem_ready, mem_instr,
        input  fetch_ready, out_valid, out_instr, out_addr, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_direct.sv
// icache_direct
// Direct-mapped instruction cache, one 32-bit word per line, 2^INDEX_BITS
// lines. Hits answer one cycle after acceptance; misses issue a word read on
// the controller fetcher port, fill the line and answer the cycle after
// mem_ready. rob_clear aborts an in-flight miss and blocks acceptance.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous reset, active low
//   rdy       : global ready, low freezes every register
//   rob_clear : pipeline flush
//   bus       : icache_direct_if.slave (fetcher + memory-controller signals)
// Optional (macro ICACHE_PERF_EN):
//   hit_cnt / miss_cnt : saturating counts of accepted hits / misses
`timescale 1ns/1ps
module icache_direct #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rob_clear,
    icache_direct_if.slave     bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);
    localparam int unsigned TAG_BITS = 32 - INDEX_BITS - 2;
    localparam int unsigned LINES    = 1 << INDEX_BITS;

    typedef enum logic {IDLE, MISS} state_e;

    state_e              state_q, state_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_instr_q, out_instr_d;
    logic [31:0]         out_addr_q, out_addr_d;
    logic                mem_req_q, mem_req_d;
    // Doubles as the latched miss address while in MISS.
    logic [31:0]         mem_addr_q, mem_addr_d;

    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    logic [31:0]           fetch_aligned;
    logic [INDEX_BITS-1:0] fetch_idx, fill_idx;
    logic [TAG_BITS-1:0]   fetch_tag, fill_tag;
    logic                  fetch_ready;
    logic                  accept;
    logic                  hit;
    logic                  fill_en;

    always_comb begin
        fetch_aligned = bus.fetch_addr & 32'hFFFF_FFFC;
        fetch_idx     = fetch_aligned[INDEX_BITS+1:2];
        fetch_tag     = fetch_aligned[31:INDEX_BITS+2];
        fill_idx      = mem_addr_q[INDEX_BITS+1:2];
        fill_tag      = mem_addr_q[31:INDEX_BITS+2];
        fetch_ready   = (state_q == IDLE) && !rob_clear;
        accept        = bus.fetch_valid && fetch_ready;
        hit           = valid_q[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        fill_en     = 1'b0;
        if (rdy) begin
            out_valid_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            out_valid_d = 1'b1;
                            out_instr_d = data_mem[fetch_idx];
                            out_addr_d  = fetch_aligned;
                        end else begin
                            state_d    = MISS;
                            mem_req_d  = 1'b1;
                            mem_addr_d = fetch_aligned;
                        end
                    end
                end
                MISS: begin
                    // Flush outranks a same-cycle completion: nothing is filled.
                    if (rob_clear) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end else if (bus.mem_ready) begin
                        fill_en           = 1'b1;
                        valid_d[fill_idx] = 1'b1;
                        out_valid_d       = 1'b1;
                        out_instr_d       = bus.mem_instr;
                        out_addr_d        = mem_addr_q;
                        state_d           = IDLE;
                        mem_req_d         = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // Tag/data storage carries no reset; valid_q guards every read.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= bus.mem_instr;
        end
    end

    assign bus.fetch_ready = fetch_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_addr    = out_addr_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (rdy && accept) begin
            if (hit) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule
